// File: rtl/biquad_cascada.sv
// Cascade of n_secc direct-form-II biquads sharing one multiplier, six steps per section.
// Define FILTRO_SATURACION_EN to clamp rounded results instead of wrapping them.
module biquad_cascada #(
  parameter int cant_bits = 25,
  parameter int frac_bits = 23,
  parameter int n_secc    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [cant_bits-1:0]          uu,
  input  logic                          limpiar,
  input  logic                          coef_we,
  input  logic [$clog2(5*n_secc)-1:0]   coef_dir,
  input  logic [cant_bits-1:0]          coef_dato,
  output logic                          busy,
  output logic                          y_valid,
  output logic [cant_bits-1:0]          y,
  output logic                          overrun
);

  localparam int CB    = cant_bits;
  localparam int FB    = frac_bits;
  localparam int NC    = 5 * n_secc;
  localparam int DIR_W = $clog2(NC);
  localparam int SEC_W = (n_secc > 1) ? $clog2(n_secc) : 1;
  localparam int PW    = 2 * CB;
  localparam int AW    = 2 * CB + 2;
  localparam logic [DIR_W:0]   NC_LIM = (DIR_W + 1)'(NC);
  localparam logic [SEC_W-1:0] ULTIMA = SEC_W'(n_secc - 1);
  localparam logic [CB-1:0]    UNO    = CB'(1) << FB;

  typedef enum logic [1:0] {IDLE, CALC, SALIDA} estado_t;

  estado_t                estado_q, estado_d;
  logic [2:0]             paso_q, paso_d;
  logic [SEC_W-1:0]       sec_q, sec_d;
  logic signed [CB-1:0]   x_q, x_d;
  logic signed [CB-1:0]   w_q, w_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic signed [CB-1:0]   w1_q [n_secc];
  logic signed [CB-1:0]   w1_d [n_secc];
  logic signed [CB-1:0]   w2_q [n_secc];
  logic signed [CB-1:0]   w2_d [n_secc];
  logic signed [CB-1:0]   coef_q [NC];
  logic [CB-1:0]          y_q, y_d;
  logic                   busy_q, busy_d;
  logic                   y_valid_q, y_valid_d;
  logic                   overrun_q, overrun_d;

  logic [DIR_W-1:0]       base;
  logic signed [CB-1:0]   mul_a, mul_b;
  logic signed [PW-1:0]   prod;
  logic signed [AW-1:0]   prod_ext, x_sh;
  logic signed [CB-1:0]   rnd_q;

  assign base = DIR_W'(sec_q) * DIR_W'(5);

  // Round half up: bits above the binary point plus the first bit below it.
`ifdef FILTRO_SATURACION_EN
  localparam logic signed [AW-1:0] SAT_MAX  = {{(AW-CB+1){1'b0}}, {(CB-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN  = {{(AW-CB+1){1'b1}}, {(CB-1){1'b0}}};
  localparam logic signed [AW-1:0] RND_HALF = {{(AW-FB){1'b0}}, 1'b1, {(FB-1){1'b0}}};
  logic signed [AW-1:0] rnd_sum, rnd_sh;
  always_comb begin
    rnd_sum = acc_q + RND_HALF;
    rnd_sh  = rnd_sum >>> FB;
    if (rnd_sh > SAT_MAX)      rnd_q = SAT_MAX[CB-1:0];
    else if (rnd_sh < SAT_MIN) rnd_q = SAT_MIN[CB-1:0];
    else                       rnd_q = rnd_sh[CB-1:0];
  end
`else
  always_comb rnd_q = acc_q[FB+CB-1:FB] + CB'(acc_q[FB-1]);
`endif

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (paso_q)
      3'd0: begin mul_a = coef_q[base + DIR_W'(3)]; mul_b = w1_q[sec_q]; end
      3'd1: begin mul_a = coef_q[base + DIR_W'(4)]; mul_b = w2_q[sec_q]; end
      3'd2: begin mul_a = coef_q[base];             mul_b = rnd_q;        end
      3'd3: begin mul_a = coef_q[base + DIR_W'(1)]; mul_b = w1_q[sec_q]; end
      3'd4: begin mul_a = coef_q[base + DIR_W'(2)]; mul_b = w2_q[sec_q]; end
      default: ;
    endcase
    prod     = $signed({{CB{mul_a[CB-1]}}, mul_a} * {{CB{mul_b[CB-1]}}, mul_b});
    prod_ext = {{(AW-PW){prod[PW-1]}}, prod};
    x_sh     = {{(AW-CB){x_q[CB-1]}}, x_q} <<< FB;
  end

  always_comb begin
    estado_d  = estado_q;
    paso_d    = paso_q;
    sec_d     = sec_q;
    x_d       = x_q;
    w_d       = w_q;
    acc_d     = acc_q;
    w1_d      = w1_q;
    w2_d      = w2_q;
    y_d       = y_q;
    busy_d    = busy_q;
    y_valid_d = 1'b0;
    overrun_d = overrun_q | (in_valid & busy_q);
    case (estado_q)
      IDLE: begin
        busy_d = 1'b0;
        if (limpiar) begin
          for (int unsigned i = 0; i < n_secc; i++) begin
            w1_d[i] = '0;
            w2_d[i] = '0;
          end
        end
        if (in_valid) begin
          x_d      = uu;
          sec_d    = '0;
          paso_d   = '0;
          busy_d   = 1'b1;
          estado_d = CALC;
        end
      end
      CALC: begin
        paso_d = (paso_q == 3'd5) ? 3'd0 : paso_q + 3'd1;
        case (paso_q)
          3'd0: acc_d = x_sh - prod_ext;
          3'd1: acc_d = acc_q - prod_ext;
          3'd2: begin w_d = rnd_q; acc_d = prod_ext; end
          3'd3, 3'd4: acc_d = acc_q + prod_ext;
          default: begin
            x_d         = rnd_q;
            w2_d[sec_q] = w1_q[sec_q];
            w1_d[sec_q] = w_q;
            if (sec_q == ULTIMA) estado_d = SALIDA;
            else                 sec_d = sec_q + SEC_W'(1);
          end
        endcase
      end
      SALIDA: begin
        y_d       = x_q;
        y_valid_d = 1'b1;
        busy_d    = 1'b0;
        estado_d  = IDLE;
      end
      default: estado_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q  <= IDLE;
      paso_q    <= '0;
      sec_q     <= '0;
      x_q       <= '0;
      w_q       <= '0;
      acc_q     <= '0;
      y_q       <= '0;
      busy_q    <= 1'b0;
      y_valid_q <= 1'b0;
      overrun_q <= 1'b0;
      for (int unsigned i = 0; i < n_secc; i++) begin
        w1_q[i] <= '0;
        w2_q[i] <= '0;
      end
      for (int unsigned i = 0; i < NC; i++) coef_q[i] <= (i % 5 == 0) ? UNO : '0;
    end else begin
      estado_q  <= estado_d;
      paso_q    <= paso_d;
      sec_q     <= sec_d;
      x_q       <= x_d;
      w_q       <= w_d;
      acc_q     <= acc_d;
      w1_q      <= w1_d;
      w2_q      <= w2_d;
      y_q       <= y_d;
      busy_q    <= busy_d;
      y_valid_q <= y_valid_d;
      overrun_q <= overrun_d;
      if (coef_we && !busy_q && ({1'b0, coef_dir} < NC_LIM)) coef_q[coef_dir] <= coef_dato;
    end
  end

  assign busy    = busy_q;
  assign y_valid = y_valid_q;
  assign y       = y_q;
  assign overrun = overrun_q;

endmodule
